// File: rtl/pacman_move_ctrl.sv
// Movement controller for pacman. On each tick it proposes the next map cell to collision_detect,
// waits for the result to settle, and then commits the move (scoring dots and pills) or holds position.
module pacman_move_ctrl #(
    parameter int MAP_W     = 40,
    parameter int MAP_H     = 30,
    parameter int START_X   = 20,
    parameter int START_Y   = 22,
    parameter int SETTLE    = 4,
    parameter int DOT_TOTAL = 244,
    parameter int DOT_PTS   = 10,
    parameter int PILL_PTS  = 50
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        tick,
    input  logic [1:0]  dir_req,
    input  logic        dir_valid,
    input  logic [3:0]  collision_type,
    output logic [5:0]  next_pacman_x,
    output logic [4:0]  next_pacman_y,
    output logic        colli_clr,
    output logic [5:0]  pacman_x,
    output logic [4:0]  pacman_y,
    output logic [1:0]  pacman_dir,
    output logic [15:0] score,
    output logic [8:0]  dots_left,
    output logic        level_clear,
    output logic        busy
);

    localparam int CNT_W = $clog2(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLR,
        S_WAIT,
        S_EVAL
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  pac_x_q, pac_x_d;
    logic [4:0]  pac_y_q, pac_y_d;
    logic [1:0]  pac_dir_q, pac_dir_d;
    logic [1:0]  q_dir_q, q_dir_d;
    logic        q_valid_q, q_valid_d;
    logic [1:0]  try_dir_q, try_dir_d;
    logic        from_q_q, from_q_d;
    logic [3:0]  cap_q, cap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0] score_q, score_d;
    logic [8:0]  dots_q, dots_d;
    logic        lc_q, lc_d;

    logic [5:0]  cand_x;
    logic [4:0]  cand_y;
    logic        edge_block;
    logic        wall;
    logic        is_item;
    logic [15:0] pts;
    logic [16:0] score_sum;

    // Candidate cell one step from the committed position; x wraps through the tunnel, y does not.
    always_comb begin
        cand_x     = pac_x_q;
        cand_y     = pac_y_q;
        edge_block = 1'b0;
        case (try_dir_q)
            2'b00: begin
                if (pac_y_q == 5'd0) edge_block = 1'b1;
                else                 cand_y     = pac_y_q - 5'd1;
            end
            2'b01: begin
                if (pac_y_q == 5'(MAP_H - 1)) edge_block = 1'b1;
                else                          cand_y     = pac_y_q + 5'd1;
            end
            2'b10:   cand_x = (pac_x_q == 6'd0) ? 6'(MAP_W - 1) : pac_x_q - 6'd1;
            default: cand_x = (pac_x_q == 6'(MAP_W - 1)) ? 6'd0 : pac_x_q + 6'd1;
        endcase
    end

    // Out-of-range capture codes fall through to zero points, i.e. a free move.
    always_comb begin
        pts     = 16'd0;
        is_item = 1'b0;
        case (cap_q)
            4'd2: begin pts = 16'(DOT_PTS);  is_item = 1'b1; end
            4'd3: begin pts = 16'(PILL_PTS); is_item = 1'b1; end
            default: ;
        endcase
        score_sum = {1'b0, score_q} + {1'b0, pts};
        wall      = edge_block || (cap_q == 4'd1);
    end

    // NOTE: every *_d gets its hold value first so no path through this block can infer a latch.
    always_comb begin
        state_d   = state_q;
        pac_x_d   = pac_x_q;
        pac_y_d   = pac_y_q;
        pac_dir_d = pac_dir_q;
        q_dir_d   = q_dir_q;
        q_valid_d = q_valid_q;
        try_dir_d = try_dir_q;
        from_q_d  = from_q_q;
        cap_d     = cap_q;
        cnt_d     = cnt_q;
        score_d   = score_q;
        dots_d    = dots_q;
        lc_d      = lc_q;

        case (state_q)
            S_IDLE: begin
                if (tick && !lc_q) begin
                    try_dir_d = q_valid_q ? q_dir_q : pac_dir_q;
                    from_q_d  = q_valid_q;
                    state_d   = S_CLR;
                end
            end
            S_CLR: begin
                cap_d   = 4'd0;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A dot or pill vanishes after its first hit, so keep the first nonzero code.
                if (cap_q == 4'd0 && collision_type != 4'd0) cap_d = collision_type;
                if (cnt_q == CNT_W'(SETTLE - 1)) state_d = S_EVAL;
                else                             cnt_d   = cnt_q + CNT_W'(1);
            end
            S_EVAL: begin
                if (wall && from_q_q && try_dir_q != pac_dir_q) begin
                    try_dir_d = pac_dir_q;
                    from_q_d  = 1'b0;
                    state_d   = S_CLR;
                end else if (wall) begin
                    state_d = S_IDLE;
                end else begin
                    pac_x_d   = cand_x;
                    pac_y_d   = cand_y;
                    pac_dir_d = try_dir_q;
                    if (from_q_q) q_valid_d = 1'b0;
                    score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    if (is_item && dots_q != 9'd0) begin
                        dots_d = dots_q - 9'd1;
                        if (dots_q == 9'd1) lc_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (dir_valid) begin
            q_dir_d   = dir_req;
            q_valid_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pac_x_q   <= 6'(START_X);
            pac_y_q   <= 5'(START_Y);
            pac_dir_q <= 2'b10;
            q_dir_q   <= 2'b00;
            q_valid_q <= 1'b0;
            try_dir_q <= 2'b10;
            from_q_q  <= 1'b0;
            cap_q     <= 4'd0;
            cnt_q     <= '0;
            score_q   <= 16'd0;
            dots_q    <= 9'(DOT_TOTAL);
            lc_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pac_x_q   <= pac_x_d;
            pac_y_q   <= pac_y_d;
            pac_dir_q <= pac_dir_d;
            q_dir_q   <= q_dir_d;
            q_valid_q <= q_valid_d;
            try_dir_q <= try_dir_d;
            from_q_q  <= from_q_d;
            cap_q     <= cap_d;
            cnt_q     <= cnt_d;
            score_q   <= score_d;
            dots_q    <= dots_d;
            lc_q      <= lc_d;
        end
    end

    assign next_pacman_x = (state_q == S_IDLE) ? pac_x_q : cand_x;
    assign next_pacman_y = (state_q == S_IDLE) ? pac_y_q : cand_y;
    assign colli_clr     = (state_q == S_CLR);
    assign pacman_x      = pac_x_q;
    assign pacman_y      = pac_y_q;
    assign pacman_dir    = pac_dir_q;
    assign score         = score_q;
    assign dots_left     = dots_q;
    assign level_clear   = lc_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Directed bench for pacman_move_ctrl: a default-map instance and an edge instance
// parked at (0,0) with a single remaining pill.
module tb_pacman_move_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_a, tick_b;
    logic [1:0]  dir_req;
    logic        dir_valid;
    logic [3:0]  collision_type;

    logic [5:0]  nx_a, x_a, nx_b, x_b;
    logic [4:0]  ny_a, y_a, ny_b, y_b;
    logic        clr_a, clr_b, lc_a, lc_b, busy_a, busy_b;
    logic [1:0]  dir_a, dir_b;
    logic [15:0] score_a, score_b;
    logic [8:0]  dots_a, dots_b;

    int n_checks = 0;
    int n_fail   = 0;
    int clr_cnt;

    always #10 clk = ~clk;

    pacman_move_ctrl dut_a (
        .CLOCK_50(clk), .reset(reset), .tick(tick_a), .dir_req(dir_req), .dir_valid(dir_valid),
        .collision_type(collision_type), .next_pacman_x(nx_a), .next_pacman_y(ny_a),
        .colli_clr(clr_a), .pacman_x(x_a), .pacman_y(y_a), .pacman_dir(dir_a),
        .score(score_a), .dots_left(dots_a), .level_clear(lc_a), .busy(busy_a)
    );

    pacman_move_ctrl #(.START_X(0), .START_Y(0), .DOT_TOTAL(1)) dut_b (
        .CLOCK_50(clk), .reset(reset), .tick(tick_b), .dir_req(dir_req), .dir_valid(dir_valid),
        .collision_type(collision_type), .next_pacman_x(nx_b), .next_pacman_y(ny_b),
        .colli_clr(clr_b), .pacman_x(x_b), .pacman_y(y_b), .pacman_dir(dir_b),
        .score(score_b), .dots_left(dots_b), .level_clear(lc_b), .busy(busy_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; tick_a = 1'b0; tick_b = 1'b0;
        dir_req = 2'b00; dir_valid = 1'b0; collision_type = 4'd0;
        step(); step();
        reset = 1'b0;
        step();

        // Reset state
        chk("rst_x",     32'(x_a), 20);
        chk("rst_y",     32'(y_a), 22);
        chk("rst_nx",    32'(nx_a), 20);
        chk("rst_ny",    32'(ny_a), 22);
        chk("rst_dir",   32'(dir_a), 2);
        chk("rst_score", 32'(score_a), 0);
        chk("rst_dots",  32'(dots_a), 244);
        chk("rst_lc",    32'(lc_a), 0);
        chk("rst_clr",   32'(clr_a), 0);
        chk("rst_busy",  32'(busy_a), 0);

        // 1: plain tick, no request, free cell -> step left; a tick during WAIT is dropped
        tick_a = 1'b1;
        step();
        tick_a = 1'b0;
        chk("t1_clr",  32'(clr_a), 1);
        chk("t1_nx",   32'(nx_a), 19);
        chk("t1_ny",   32'(ny_a), 22);
        chk("t1_busy", 32'(busy_a), 1);
        step();
        chk("t1_clr_once", 32'(clr_a), 0);
        tick_a = 1'b1;
        step();
        tick_a = 1'b0;
        step(); step(); step();
        chk("t1_no_early", 32'(x_a), 20);
        step();
        chk("t1_x",     32'(x_a), 19);
        chk("t1_y",     32'(y_a), 22);
        chk("t1_dir",   32'(dir_a), 2);
        chk("t1_score", 32'(score_a), 0);
        chk("t1_idle",  32'(busy_a), 0);
        step();
        chk("t1_drop",  32'(busy_a), 0);

        // 2: queued up, dot seen for one WAIT cycle only
        dir_req = 2'b00; dir_valid = 1'b1;
        step();
        dir_valid = 1'b0;
        tick_a = 1'b1;
        step();
        tick_a = 1'b0;
        chk("t2_ny", 32'(ny_a), 21);
        step();
        collision_type = 4'd2;
        step();
        collision_type = 4'd0;
        step(); step(); step(); step();
        chk("t2_x",     32'(x_a), 19);
        chk("t2_y",     32'(y_a), 21);
        chk("t2_dir",   32'(dir_a), 0);
        chk("t2_score", 32'(score_a), 10);
        chk("t2_dots",  32'(dots_a), 243);

        // 3: queued right hits a wall, second probe in current dir (up) is free
        dir_req = 2'b11; dir_valid = 1'b1;
        step();
        dir_valid = 1'b0;
        clr_cnt = 0;
        tick_a = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step();
            if (i == 0) begin
                tick_a = 1'b0;
                collision_type = 4'd1;
                chk("t3_nx_first", 32'(nx_a), 20);
            end
            if (i == 6) begin
                collision_type = 4'd0;
                chk("t3_ny_second", 32'(ny_a), 20);
            end
            if (clr_a) clr_cnt++;
            if (i == 11) chk("t3_no_early", 32'(y_a), 21);
        end
        chk("t3_clr_pulses", 32'(clr_cnt), 2);
        chk("t3_x",    32'(x_a), 19);
        chk("t3_y",    32'(y_a), 20);
        chk("t3_dir",  32'(dir_a), 0);
        chk("t3_busy", 32'(busy_a), 0);
        chk("t3_score", 32'(score_a), 10);

        // Queue still holds right: the next free tick goes right
        tick_a = 1'b1;
        step();
        tick_a = 1'b0;
        step(); step(); step(); step(); step(); step();
        chk("t3q_x",   32'(x_a), 20);
        chk("t3q_y",   32'(y_a), 20);
        chk("t3q_dir", 32'(dir_a), 3);

        // 4/5: edge instance at (0,0). Up is off-map -> second probe left wraps to 39 onto the last pill
        dir_req = 2'b00; dir_valid = 1'b1;
        step();
        dir_valid = 1'b0;
        collision_type = 4'd3;
        tick_b = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step();
            if (i == 0) begin
                tick_b = 1'b0;
                chk("t4_ny_blocked", 32'(ny_b), 0);
            end
            if (i == 6) chk("t4_nx_wrap", 32'(nx_b), 39);
            if (i == 11) begin
                chk("t5_lc_early",   32'(lc_b), 0);
                chk("t5_dots_early", 32'(dots_b), 1);
            end
        end
        chk("t4_x",     32'(x_b), 39);
        chk("t4_y",     32'(y_b), 0);
        chk("t4_dir",   32'(dir_b), 2);
        chk("t4_score", 32'(score_b), 50);
        chk("t5_dots",  32'(dots_b), 0);
        chk("t5_lc",    32'(lc_b), 1);
        collision_type = 4'd0;
        tick_b = 1'b1;
        step();
        tick_b = 1'b0;
        chk("t5_frozen_busy", 32'(busy_b), 0);
        step(); step(); step(); step(); step(); step();
        chk("t5_frozen_x", 32'(x_b), 39);
        chk("t5_lc_hold",  32'(lc_b), 1);

        // 6: reset in the middle of WAIT of a dot probe
        collision_type = 4'd2;
        tick_a = 1'b1;
        step();
        tick_a = 1'b0;
        step(); step();
        chk("t6_busy_pre", 32'(busy_a), 1);
        reset = 1'b1;
        step();
        chk("t6_x",     32'(x_a), 20);
        chk("t6_y",     32'(y_a), 22);
        chk("t6_nx",    32'(nx_a), 20);
        chk("t6_score", 32'(score_a), 0);
        chk("t6_dots",  32'(dots_a), 244);
        chk("t6_clr",   32'(clr_a), 0);
        chk("t6_busy",  32'(busy_a), 0);
        chk("t6_dir",   32'(dir_a), 2);
        reset = 1'b0;
        collision_type = 4'd0;
        step();
        chk("t6_stay_idle", 32'(busy_a), 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
